pipe_reg_skid: RTL and testbench

- Elastic pipeline stage register.
- Adds a valid/ready handshake, a 2-entry skid buffer, flush, and stall to the plain flush/stall stage register.
- Decouples the upstream ready path from downstream backpressure, so ready never passes combinationally from out_ready to in_ready.
- Placed between CPU pipeline stages (e.g. IF/ID, ID/EX) wherever the neighbouring stages are allowed to backpressure.

---
 rtl/pipe_reg_skid.sv | 145 ++++++++++++++
 tb/tb_pipe_reg_skid.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_skid.sv
// -----------------------------------------------------------------------------
// pipe_reg_skid
//
// Elastic pipeline stage register with a valid/ready handshake, a 2-entry
// skid buffer (main + skid), synchronous flush and output-side stall.
// in_ready is derived only from registered occupancy and reset. There is no
// combinational path from out_ready or stall to in_ready, so backpressure
// does not ripple upstream within a cycle.
//
// Ports:
//   clk        in   1      clock, all state updates on posedge
//   rst        in   1      asynchronous, active-low reset
//   flush      in   1      synchronous flush, discards all held entries
//   stall      in   1      freezes the output side (suppresses fire)
//   in_valid   in   1      upstream has data
//   in_ready   out  1      stage can accept data this cycle
//   in_data    in   BW     upstream payload
//   out_valid  out  1      stage holds data for downstream
//   out_ready  in   1      downstream accepts data
//   out_data   out  BW     payload presented downstream (main register)
//   occupancy  out  2      number of held entries, 0..2
//   bp_cnt     out  CNT_W  saturating count of backpressured cycles
// -----------------------------------------------------------------------------
module pipe_reg_skid #(
   parameter int BW             = 256,
   parameter bit CLEAR_ON_FLUSH = 1'b1,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             stall,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BW-1:0]    in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BW-1:0]    out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] bp_cnt
);

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   occ_e             occ_q, occ_d;
   logic [BW-1:0]    main_q, main_d;
   logic [BW-1:0]    skid_q, skid_d;
   logic [CNT_W-1:0] bp_q, bp_d;

   logic             accept;
   logic             fire;

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == {CNT_W{1'b1}}) r = v;
      else                    r = v + {{(CNT_W-1){1'b0}}, 1'b1};
      return r;
   endfunction

   // Handshake terms. in_ready includes rst so that it is 0 during reset
   // without waiting for an edge.
   assign in_ready  = rst & (occ_q != OCC_FULL);
   assign out_valid = (occ_q != OCC_EMPTY);
   assign out_data  = main_q;
   assign occupancy = occ_q;
   assign bp_cnt    = bp_q;

   assign accept = in_valid & in_ready;
   assign fire   = out_valid & out_ready & ~stall;

   // Next-state for occupancy and data registers.
   always_comb begin
      occ_d  = occ_q;
      main_d = main_q;
      skid_d = skid_q;

      if (flush) begin
         // Any same-cycle accept or fire is dropped: the handshake completed
         // upstream/downstream but the entry is discarded here.
         occ_d = OCC_EMPTY;
         if (CLEAR_ON_FLUSH) begin
            main_d = '0;
            skid_d = '0;
         end
      end else begin
         unique case (occ_q)
            OCC_EMPTY: begin
               if (accept) begin
                  occ_d  = OCC_ONE;
                  main_d = in_data;
               end
            end
            OCC_ONE: begin
               if (accept && fire) begin
                  main_d = in_data;
               end else if (accept) begin
                  occ_d  = OCC_FULL;
                  skid_d = in_data;
               end else if (fire) begin
                  // main keeps its (now stale) value on drain.
                  occ_d = OCC_EMPTY;
               end
            end
            OCC_FULL: begin
               // in_ready is low here, so only the output side can move.
               if (fire) begin
                  occ_d  = OCC_ONE;
                  main_d = skid_q;
               end
            end
            default: begin
               // Unreachable encoding; recover to empty.
               occ_d = OCC_EMPTY;
            end
         endcase
      end
   end

   // Backpressure counter: a cycle counts when data is offered but not taken,
   // including cycles where stall blocks the transfer. Flush does not clear it.
   always_comb begin
      bp_d = bp_q;
      if (out_valid && !fire) bp_d = sat_inc(bp_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ_q  <= OCC_EMPTY;
         main_q <= '0;
         skid_q <= '0;
         bp_q   <= '0;
      end else begin
         occ_q  <= occ_d;
         main_q <= main_d;
         skid_q <= skid_d;
         bp_q   <= bp_d;
      end
   end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_reg_skid
//
// Directed bench for pipe_reg_skid. Two instances: the main one (BW=8,
// CLEAR_ON_FLUSH=1, CNT_W=16) and a small one (BW=8, CLEAR_ON_FLUSH=0,
// CNT_W=2) for counter saturation and data-preserving flush.
// -----------------------------------------------------------------------------
module tb_pipe_reg_skid;

   localparam int BW = 8;

   logic          clk;
   logic          rst;

   logic          flush, stall, in_valid, out_ready;
   logic [BW-1:0] in_data;
   logic          in_ready, out_valid;
   logic [BW-1:0] out_data;
   logic [1:0]    occupancy;
   logic [15:0]   bp_cnt;

   logic          flush2, stall2, in_valid2, out_ready2;
   logic [BW-1:0] in_data2;
   logic          in_ready2, out_valid2;
   logic [BW-1:0] out_data2;
   logic [1:0]    occupancy2;
   logic [1:0]    bp_cnt2;

   int checks;
   int errors;

   pipe_reg_skid #(.BW(BW), .CLEAR_ON_FLUSH(1'b1), .CNT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .stall     (stall),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy),
      .bp_cnt    (bp_cnt)
   );

   pipe_reg_skid #(.BW(BW), .CLEAR_ON_FLUSH(1'b0), .CNT_W(2)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush2),
      .stall     (stall2),
      .in_valid  (in_valid2),
      .in_ready  (in_ready2),
      .in_data   (in_data2),
      .out_valid (out_valid2),
      .out_ready (out_ready2),
      .out_data  (out_data2),
      .occupancy (occupancy2),
      .bp_cnt    (bp_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      flush = 0; stall = 0; in_valid = 0; out_ready = 0; in_data = '0;
      flush2 = 0; stall2 = 0; in_valid2 = 0; out_ready2 = 0; in_data2 = '0;

      // ---------------- reset state ----------------
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_bp", bp_cnt, 0);
      step();
      step();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      // ---------------- stream 0x01..0x05 ----------------
      @(posedge clk);
      #1;
      out_ready = 1;
      for (int i = 1; i <= 5; i++) begin
         in_valid = 1;
         in_data  = BW'(i);
         step();
         chk("stream_valid", out_valid, 1);
         chk("stream_data", out_data, i);
         chk("stream_in_ready", in_ready, 1);
      end
      in_valid = 0;
      step();
      chk("drain_valid", out_valid, 0);
      chk("drain_stale_data", out_data, 8'h05);
      chk("stream_bp", bp_cnt, 0);

      // ---------------- fill to FULL with out_ready=0 ----------------
      out_ready = 0;
      in_valid = 1; in_data = 8'hA1;
      step();
      chk("fill_occ1", occupancy, 1);
      chk("fill_in_ready1", in_ready, 1);
      chk("fill_data_A", out_data, 8'hA1);
      in_data = 8'hB2;
      step();
      chk("fill_occ2", occupancy, 2);
      chk("fill_in_ready0", in_ready, 0);
      chk("fill_bp1", bp_cnt, 1);
      in_valid = 0;

      // ---------------- stall while FULL ----------------
      out_ready = 1; stall = 1;
      step();
      chk("stall_bp_a", bp_cnt, 2);
      step();
      chk("stall_bp_b", bp_cnt, 3);
      step();
      chk("stall_bp_c", bp_cnt, 4);
      chk("stall_data_A", out_data, 8'hA1);
      chk("stall_occ", occupancy, 2);
      stall = 0;
      step();
      chk("unstall_data_B", out_data, 8'hB2);
      chk("unstall_occ", occupancy, 1);
      chk("unstall_in_ready", in_ready, 1);
      chk("unstall_bp", bp_cnt, 4);
      step();
      chk("b_out_valid", out_valid, 0);
      chk("b_stale", out_data, 8'hB2);

      // ---------------- flush from FULL ----------------
      out_ready = 0;
      in_valid = 1; in_data = 8'hC3;
      step();
      in_data = 8'hD4;
      step();
      chk("pre_flush_occ", occupancy, 2);
      chk("pre_flush_bp", bp_cnt, 5);
      in_data = 8'hE5; flush = 1;
      step();
      chk("flush_occ", occupancy, 0);
      chk("flush_valid", out_valid, 0);
      chk("flush_data", out_data, 0);
      chk("flush_in_ready", in_ready, 1);
      chk("flush_bp_kept", bp_cnt, 6);

      // flush coinciding with accept and fire drops the new entry
      flush = 0; in_data = 8'hF6;
      step();
      chk("f6_data", out_data, 8'hF6);
      flush = 1; out_ready = 1; in_data = 8'h77;
      step();
      chk("flush_acc_occ", occupancy, 0);
      chk("flush_acc_data", out_data, 0);
      chk("flush_acc_bp", bp_cnt, 6);
      flush = 0; in_valid = 0;
      step();
      chk("flush_drop_valid", out_valid, 0);
      chk("flush_drop_data", out_data, 0);

      // ---------------- async reset with occupancy=2 ----------------
      out_ready = 0;
      in_valid = 1; in_data = 8'h11;
      step();
      in_data = 8'h22;
      step();
      chk("pre_rst_occ", occupancy, 2);
      in_valid = 0;
      #3;
      rst = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 0);
      chk("arst_data", out_data, 0);
      chk("arst_occ", occupancy, 0);
      chk("arst_bp", bp_cnt, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1; in_data = 8'h5A; out_ready = 1;
      step();
      chk("post_arst_valid", out_valid, 1);
      chk("post_arst_data", out_data, 8'h5A);
      in_valid = 0;
      step();
      chk("post_arst_drain", out_valid, 0);

      // ---------------- CNT_W=2 saturation, CLEAR_ON_FLUSH=0 ----------------
      in_valid2 = 1; in_data2 = 8'h33; out_ready2 = 0;
      step();
      chk("sat_load", out_data2, 8'h33);
      chk("sat_bp0", bp_cnt2, 0);
      in_valid2 = 0;
      step(); chk("sat_bp_1", bp_cnt2, 1);
      step(); chk("sat_bp_2", bp_cnt2, 2);
      step(); chk("sat_bp_3", bp_cnt2, 3);
      step(); chk("sat_bp_4", bp_cnt2, 3);
      step(); chk("sat_bp_5", bp_cnt2, 3);
      step(); chk("sat_bp_6", bp_cnt2, 3);
      flush2 = 1;
      step();
      chk("noclr_flush_occ", occupancy2, 0);
      chk("noclr_flush_valid", out_valid2, 0);
      chk("noclr_flush_data", out_data2, 8'h33);
      flush2 = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard time bound so the bench always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
